// File: rtl/xbar_master_port.sv
// Master-side request buffer for one port of the 2x2 req/ack crossbar: FIFO in, one outstanding txn, completion out.
// Optional ack-timeout abort is enabled by defining XBAR_MPORT_TIMEOUT_EN.
module xbar_master_port #(
    parameter int N       = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_addr,
    input  logic                       in_cmd,
    input  logic [N-1:0]               in_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [N-1:0]               rsp_rdata,
    output logic                       rsp_cmd,
    output logic                       rsp_err,
    output logic                       xb_req,
    output logic [N-1:0]               xb_addr,
    output logic                       xb_cmd,
    output logic [N-1:0]               xb_wdata,
    input  logic                       xb_ack,
    input  logic [N-1:0]               xb_rdata,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [N-1:0] addr;
        logic         cmd;
        logic [N-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_n;
    req_t            mem [DEPTH];
    req_t            head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop, done, tmo;

    assign in_ready   = (count < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_count = count;
    assign head       = mem[rd_ptr];

`ifdef XBAR_MPORT_TIMEOUT_EN
    localparam int WW = (TIMEOUT >= 256) ? $clog2(TIMEOUT + 1) : 8;
    logic [WW-1:0] wcnt;

    // Fires on the TIMEOUT-th WAIT cycle; a simultaneous ack takes priority.
    assign tmo = (state == WAIT) && !xb_ack && (wcnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        wcnt <= '0;
        else if (pop)                    wcnt <= '0;
        else if (state == WAIT && !xb_ack) wcnt <= wcnt + WW'(1);
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign tmo            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (count != '0) state_n = WAIT;
            WAIT:    if (xb_ack || tmo) state_n = RESP;
            RESP:    if (rsp_ready) state_n = (count != '0) ? WAIT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        pop  = (count != '0) && ((state == IDLE) || (state == RESP && rsp_ready));
        done = (state == WAIT) && (xb_ack || tmo);
    end

    // Storage needs no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: in_addr, cmd: in_cmd, wdata: in_wdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xb_req    <= 1'b0;
            xb_addr   <= '0;
            xb_cmd    <= 1'b0;
            xb_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_cmd   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (pop) begin
                xb_req   <= 1'b1;
                xb_addr  <= head.addr;
                xb_cmd   <= head.cmd;
                xb_wdata <= head.wdata;
            end else if (done) begin
                xb_req <= 1'b0;
            end
            if (done) begin
                rsp_valid <= 1'b1;
                rsp_cmd   <= xb_cmd;
                rsp_err   <= tmo;
                rsp_rdata <= (xb_cmd || tmo) ? '0 : xb_rdata;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule
